pdua_int_ctrl: RTL and testbench
================================

Name: pdua_int_ctrl

Overview:
Multi-source interrupt controller for the PDUA core. It generalises the single-bit interrupt latch into N_SRC maskable lines, each edge- or level-triggered, with a fixed-priority encoder. It drives one request line (intp) and a source vector into the control unit. The control unit handshakes with int_ack when it enters the ISR and with int_clr (control word bit 4) when it leaves.

Parameters:
N_SRC, 4, number of interrupt sources (1..16)
VEC_W, 2, width of int_vec; must be >= clog2(N_SRC), minimum 1
EDGE_MODE, 1, 1 = rising-edge triggered, 0 = level triggered (applies to all sources)
MASK_RST, all ones, reset value of the mask register (1 = enabled)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
int_src  in  N_SRC  raw interrupt lines, already synchronous to clk
mask_wr_en  in  1  load mask_din into the mask register
mask_din  in  N_SRC  new mask value
int_ack  in  1  control unit accepts the request (ISR entry)
int_clr  in  1  control unit ends service (ISR return)
intp  out  1  interrupt request to the control unit
int_vec  out  VEC_W  index of the source being requested or served
int_mask  out  N_SRC  current mask register
pending  out  N_SRC  current pending register
busy  out  1  high while in SERVICE

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, pending=0, int_mask=MASK_RST, int_vec=0, intp=0, busy=0.
  - prev_src <= int_src, so a line already high at reset does not produce a spurious edge.
- Event detect, evaluated every cycle:
  - Edge mode: ev[i] = int_src[i] & ~prev_src[i]; prev_src <= int_src.
  - Level mode: ev[i] = int_src[i].
  - pending[i] <= 1 when ev[i] = 1, regardless of mask (masked events stay pending).
- Pending clear:
  - pending[int_vec] <= 0 at the edge where int_ack is accepted in REQ.
  - If ev on that same bit in that same cycle, set wins and pending stays 1.
- Mask:
  - int_mask <= mask_din on mask_wr_en.
  - Arbitration in any cycle uses the registered (old) mask.
- Arbitration: act = pending & int_mask; winner = lowest set index (bit 0 highest priority).
- FSM, all transitions on clk:
  - IDLE: if act != 0 -> REQ, int_vec <= winner. intp=0, busy=0.
  - REQ: intp=1.
    - int_ack=1 -> SERVICE, clear pending[int_vec].
    - Else if act[int_vec]=0 (source masked meanwhile) -> IDLE; the request is withdrawn and intp drops next cycle.
    - int_vec is frozen in REQ: a higher-priority arrival does not preempt; it is served next.
    - int_clr is ignored in REQ.
  - SERVICE: intp=0, busy=1, int_vec holds.
    - int_clr=1 -> IDLE.
    - int_ack is ignored; no nesting.
- Latency:
  - Edge on int_src sampled at edge k: pending visible after k, intp visible after k+1.
  - After int_clr at edge m, the next pending source raises intp after edge m+1 (one IDLE cycle minimum).
- Level mode: a line still high after service re-pends next cycle. The ISR is responsible for deasserting the source.
- Reset mid-operation: returns to IDLE with all state cleared, from any state, in one cycle.
- int_vec bits above clog2(N_SRC) are zero.

Test Plan:
1. Reset with int_src=4'b0010 held high, EDGE_MODE=1 -> pending stays 0 and intp stays 0 for 10 cycles.
2. Rising edge on int_src[2] at edge k -> pending=4'b0100 after k, intp=1 and int_vec=2 after k+1. Then int_ack -> pending=0, busy=1, intp=0. Then int_clr -> IDLE.
3. Edges on bits 3 and 1 in the same cycle -> int_vec=1 served first. After int_clr, int_vec=3 requested exactly one IDLE cycle later.
4. mask_din=4'b1110 written, then edge on bit 0 -> pending[0]=1, intp stays 0. Writing mask 4'b1111 -> intp=1, int_vec=0 two cycles after the write.
5. In REQ with int_vec=2, clear mask bit 2 -> intp drops, state IDLE, pending[2] still 1. Edge on bit 2 in the int_ack cycle -> pending[2] remains 1 after ack.
6. EDGE_MODE=0, int_src[0] held high through service -> after int_clr, intp re-asserts with int_vec=0. rst asserted in SERVICE -> busy=0, pending=0 the next cycle.

Source files
------------

// File: rtl/pdua_int_ctrl_if.sv
// Handshake bundle between the PDUA interrupt controller and its control unit.
// The slave side is the controller; the master side drives sources and acks.
interface pdua_int_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int VEC_W = 2
);
  logic [N_SRC-1:0] int_src;
  logic             mask_wr_en;
  logic [N_SRC-1:0] mask_din;
  logic             int_ack;
  logic             int_clr;
  logic             intp;
  logic [VEC_W-1:0] int_vec;
  logic [N_SRC-1:0] int_mask;
  logic [N_SRC-1:0] pending;
  logic             busy;

  modport master (
    output int_src, mask_wr_en, mask_din,
    output int_ack, int_clr,
    input  intp, int_vec, int_mask,
    input  pending, busy
  );

  modport slave (
    input  int_src, mask_wr_en, mask_din,
    input  int_ack, int_clr,
    output intp, int_vec, int_mask,
    output pending, busy
  );
endinterface

// File: rtl/pdua_int_ctrl.sv
// Multi-source maskable interrupt controller for the PDUA core:
// edge/level capture, fixed priority (bit 0 first), REQ/SERVICE handshake.
module pdua_int_ctrl #(
  parameter int               N_SRC     = 4,
  parameter int               VEC_W     = 2,
  parameter bit               EDGE_MODE = 1'b1,
  parameter logic [N_SRC-1:0] MASK_RST  = '1
) (
  input logic            clk,
  input logic            rst,
  pdua_int_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_SRC-1:0] prev_src;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_nxt;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] ev;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] sel;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] vec_nxt;
  logic [VEC_W-1:0] winner;
  logic             ack_take;

  assign ev  = EDGE_MODE ? (bus.int_src & ~prev_src)
                         : bus.int_src;
  assign act = pend_q & mask_q;
  assign sel = N_SRC'(1) << vec_q;

  // Scan downward so the lowest active index wins.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act[i]) winner = VEC_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_q;
    ack_take  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|act) begin
          state_nxt = REQ;
          vec_nxt   = winner;
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          state_nxt = SERVICE;
          ack_take  = 1'b1;
        end else if (~|(act & sel)) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (bus.int_clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new event on the acked line re-sets it in the same cycle.
  assign pend_nxt = (pend_q & ~(ack_take ? sel : '0)) | ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend_q   <= '0;
      mask_q   <= MASK_RST;
      vec_q    <= '0;
      prev_src <= bus.int_src;
    end else begin
      state    <= state_nxt;
      pend_q   <= pend_nxt;
      vec_q    <= vec_nxt;
      prev_src <= bus.int_src;
      if (bus.mask_wr_en) mask_q <= bus.mask_din;
    end
  end

  assign bus.intp     = (state == REQ);
  assign bus.busy     = (state == SERVICE);
  assign bus.int_vec  = vec_q;
  assign bus.int_mask = mask_q;
  assign bus.pending  = pend_q;
endmodule

// File: tb/tb_pdua_int_ctrl.sv
// Bench for pdua_int_ctrl: directed vector table, hand sequences, and
// random traffic on edge- and level-mode instances against a reference model.
module tb_pdua_int_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pdua_int_ctrl_if #(.N_SRC(4), .VEC_W(2)) bus_e ();
  pdua_int_ctrl_if #(.N_SRC(4), .VEC_W(2)) bus_l ();

  pdua_int_ctrl #(
    .N_SRC(4), .VEC_W(2), .EDGE_MODE(1'b1), .MASK_RST(4'hF)
  ) u_edge (
    .clk(clk), .rst(rst), .bus(bus_e)
  );

  pdua_int_ctrl #(
    .N_SRC(4), .VEC_W(2), .EDGE_MODE(1'b0), .MASK_RST(4'hF)
  ) u_lvl (
    .clk(clk), .rst(rst), .bus(bus_l)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] src;
    logic       wr;
    logic [3:0] din;
    logic       ack;
    logic       clr;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic       intp;
    logic [1:0] vec;
    logic [3:0] pend;
    logic [3:0] mask;
    logic       busy;
  } row_t;

  // Model: st 0 = waiting, 1 = requesting, 2 = in service.
  typedef struct packed {
    logic [3:0] pend;
    logic [3:0] mask;
    logic [3:0] prev;
    logic [1:0] vec;
    logic [1:0] st;
  } mdl_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  mdl_t me;
  mdl_t ml;
  row_t tbl[31];

  function automatic in_t mi(logic r, logic [3:0] s, logic w,
                             logic [3:0] d, logic a, logic c);
    in_t x;
    x.rst = r; x.src = s; x.wr = w;
    x.din = d; x.ack = a; x.clr = c;
    return x;
  endfunction

  function automatic row_t mr(in_t x, logic ei, logic [1:0] ev,
                              logic [3:0] ep, logic [3:0] em,
                              logic eb);
    row_t r;
    r.in = x; r.intp = ei; r.vec = ev;
    r.pend = ep; r.mask = em; r.busy = eb;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, in_t x, bit edge_m);
    mdl_t       n;
    logic [3:0] ev;
    logic [3:0] act;
    int         first;
    n = m;
    if (x.rst) begin
      n.pend = '0; n.mask = 4'hF; n.prev = x.src;
      n.vec = '0; n.st = 2'd0;
      return n;
    end
    ev = edge_m ? (x.src & ~m.prev) : x.src;
    act = m.pend & m.mask;
    n.prev = x.src;
    if (x.wr) n.mask = x.din;
    if (m.st == 2'd1 && x.ack) n.pend[m.vec] = 1'b0;
    n.pend = n.pend | ev;
    case (m.st)
      2'd0: if (act != 0) begin
        first = -1;
        for (int i = 0; i < 4; i++)
          if (act[i] && first < 0) first = i;
        n.st = 2'd1;
        n.vec = 2'(first);
      end
      2'd1: begin
        if (x.ack) n.st = 2'd2;
        else if (!act[m.vec]) n.st = 2'd0;
      end
      2'd2: if (x.clr) n.st = 2'd0;
      default: n.st = 2'd0;
    endcase
    return n;
  endfunction

  task automatic cyc(in_t x);
    rst = x.rst;
    bus_e.int_src = x.src; bus_l.int_src = x.src;
    bus_e.mask_wr_en = x.wr; bus_l.mask_wr_en = x.wr;
    bus_e.mask_din = x.din; bus_l.mask_din = x.din;
    bus_e.int_ack = x.ack; bus_l.int_ack = x.ack;
    bus_e.int_clr = x.clr; bus_l.int_clr = x.clr;
    @(posedge clk);
    me = step(me, x, 1'b1);
    ml = step(ml, x, 1'b0);
    #1;
  endtask

  task automatic chk(string nm, logic ai, logic [1:0] av,
                     logic [3:0] ap, logic [3:0] am, logic ab,
                     logic ei, logic [1:0] ev, logic [3:0] ep,
                     logic [3:0] em, logic eb);
    n_cmp++;
    if ({ai, av, ap, am, ab} !== {ei, ev, ep, em, eb}) begin
      n_bad++;
      $display("FAIL %s: got intp=%b vec=%0d pend=%b mask=%b busy=%b, want intp=%b vec=%0d pend=%b mask=%b busy=%b",
               nm, ai, av, ap, am, ab, ei, ev, ep, em, eb);
    end
  endtask

  task automatic chk_e(string nm, logic ei, logic [1:0] ev,
                       logic [3:0] ep, logic [3:0] em, logic eb);
    chk(nm, bus_e.intp, bus_e.int_vec, bus_e.pending,
        bus_e.int_mask, bus_e.busy, ei, ev, ep, em, eb);
  endtask

  task automatic chk_l(string nm, logic ei, logic [1:0] ev,
                       logic [3:0] ep, logic [3:0] em, logic eb);
    chk(nm, bus_l.intp, bus_l.int_vec, bus_l.pending,
        bus_l.int_mask, bus_l.busy, ei, ev, ep, em, eb);
  endtask

  initial begin
    in_t z;
    in_t x;
    me = '0;
    ml = '0;
    z = mi(0, 4'b0000, 0, 4'h0, 0, 0);

    tbl[0]  = mr(z,                            0, 0, 4'b0000, 4'hF, 0);
    tbl[1]  = mr(mi(0, 4'b0100, 0, 0, 0, 0),   0, 0, 4'b0100, 4'hF, 0);
    tbl[2]  = mr(mi(0, 4'b0100, 0, 0, 0, 0),   1, 2, 4'b0100, 4'hF, 0);
    tbl[3]  = mr(mi(0, 4'b0000, 0, 0, 1, 0),   0, 2, 4'b0000, 4'hF, 1);
    tbl[4]  = mr(z,                            0, 2, 4'b0000, 4'hF, 1);
    tbl[5]  = mr(mi(0, 4'b0000, 0, 0, 0, 1),   0, 2, 4'b0000, 4'hF, 0);
    tbl[6]  = mr(mi(0, 4'b1010, 0, 0, 0, 0),   0, 2, 4'b1010, 4'hF, 0);
    tbl[7]  = mr(z,                            1, 1, 4'b1010, 4'hF, 0);
    tbl[8]  = mr(mi(0, 4'b0000, 0, 0, 1, 0),   0, 1, 4'b1000, 4'hF, 1);
    tbl[9]  = mr(mi(0, 4'b0000, 0, 0, 0, 1),   0, 1, 4'b1000, 4'hF, 0);
    tbl[10] = mr(z,                            1, 3, 4'b1000, 4'hF, 0);
    tbl[11] = mr(mi(0, 4'b0000, 0, 0, 1, 0),   0, 3, 4'b0000, 4'hF, 1);
    tbl[12] = mr(mi(0, 4'b0000, 0, 0, 0, 1),   0, 3, 4'b0000, 4'hF, 0);
    tbl[13] = mr(mi(0, 4'b0000, 1, 4'b1110, 0, 0),
                                               0, 3, 4'b0000, 4'hE, 0);
    tbl[14] = mr(mi(0, 4'b0001, 0, 0, 0, 0),   0, 3, 4'b0001, 4'hE, 0);
    tbl[15] = mr(z,                            0, 3, 4'b0001, 4'hE, 0);
    tbl[16] = mr(mi(0, 4'b0000, 1, 4'b1111, 0, 0),
                                               0, 3, 4'b0001, 4'hF, 0);
    tbl[17] = mr(z,                            1, 0, 4'b0001, 4'hF, 0);
    tbl[18] = mr(mi(0, 4'b0000, 0, 0, 1, 0),   0, 0, 4'b0000, 4'hF, 1);
    tbl[19] = mr(mi(0, 4'b0000, 0, 0, 0, 1),   0, 0, 4'b0000, 4'hF, 0);
    tbl[20] = mr(mi(0, 4'b0100, 0, 0, 0, 0),   0, 0, 4'b0100, 4'hF, 0);
    tbl[21] = mr(z,                            1, 2, 4'b0100, 4'hF, 0);
    tbl[22] = mr(mi(0, 4'b0000, 1, 4'b1011, 0, 0),
                                               1, 2, 4'b0100, 4'hB, 0);
    tbl[23] = mr(z,                            0, 2, 4'b0100, 4'hB, 0);
    tbl[24] = mr(mi(0, 4'b0000, 1, 4'b1111, 0, 0),
                                               0, 2, 4'b0100, 4'hF, 0);
    tbl[25] = mr(z,                            1, 2, 4'b0100, 4'hF, 0);
    tbl[26] = mr(mi(0, 4'b0100, 0, 0, 1, 0),   0, 2, 4'b0100, 4'hF, 1);
    tbl[27] = mr(mi(0, 4'b0000, 0, 0, 0, 1),   0, 2, 4'b0100, 4'hF, 0);
    tbl[28] = mr(z,                            1, 2, 4'b0100, 4'hF, 0);
    tbl[29] = mr(mi(0, 4'b0000, 0, 0, 1, 0),   0, 2, 4'b0000, 4'hF, 1);
    tbl[30] = mr(mi(0, 4'b0000, 0, 0, 0, 1),   0, 2, 4'b0000, 4'hF, 0);

    // Line already high through reset must not look like an edge.
    x = mi(1, 4'b0010, 0, 0, 0, 0);
    cyc(x);
    cyc(x);
    chk_e("reset", 0, 0, 4'b0000, 4'hF, 0);
    x.rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(x);
      chk_e($sformatf("held_hi_%0d", i), 0, 0, 4'b0000, 4'hF, 0);
    end

    for (int i = 0; i < 31; i++) begin
      cyc(tbl[i].in);
      chk_e($sformatf("row_%0d", i), tbl[i].intp, tbl[i].vec,
            tbl[i].pend, tbl[i].mask, tbl[i].busy);
    end

    // Level mode: held source re-pends through service; reset in SERVICE.
    cyc(mi(1, 4'b0000, 0, 0, 0, 0));
    chk_l("lvl_reset", 0, 0, 4'b0000, 4'hF, 0);
    cyc(mi(0, 4'b0001, 0, 0, 0, 0));
    chk_l("lvl_pend", 0, 0, 4'b0001, 4'hF, 0);
    cyc(mi(0, 4'b0001, 0, 0, 0, 0));
    chk_l("lvl_req", 1, 0, 4'b0001, 4'hF, 0);
    cyc(mi(0, 4'b0001, 0, 0, 1, 0));
    chk_l("lvl_ack_setwins", 0, 0, 4'b0001, 4'hF, 1);
    cyc(mi(0, 4'b0001, 0, 0, 0, 1));
    chk_l("lvl_clr", 0, 0, 4'b0001, 4'hF, 0);
    cyc(mi(0, 4'b0001, 0, 0, 0, 0));
    chk_l("lvl_rereq", 1, 0, 4'b0001, 4'hF, 0);
    cyc(mi(0, 4'b0001, 0, 0, 1, 0));
    chk_l("lvl_svc2", 0, 0, 4'b0001, 4'hF, 1);
    cyc(mi(1, 4'b0001, 0, 0, 0, 0));
    chk_l("lvl_rst_svc", 0, 0, 4'b0000, 4'hF, 0);

    cyc(mi(1, 4'b0000, 0, 0, 0, 0));
    for (int i = 0; i < 600; i++) begin
      x.rst = ($urandom_range(0, 99) == 0);
      x.src = 4'($urandom);
      x.wr  = ($urandom_range(0, 9) == 0);
      x.din = 4'($urandom);
      x.ack = ($urandom_range(0, 2) == 0);
      x.clr = ($urandom_range(0, 2) == 0);
      cyc(x);
      chk_e($sformatf("rnd_e_%0d", i), me.st == 2'd1, me.vec,
            me.pend, me.mask, me.st == 2'd2);
      chk_l($sformatf("rnd_l_%0d", i), ml.st == 2'd1, ml.vec,
            ml.pend, ml.mask, ml.st == 2'd2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
